// File: rtl/cond_pkg.sv
// Condition-code encodings and CPSR flag positions shared by the issue queue
// and any other unit that evaluates ARM-style condition fields.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

endpackage

// File: rtl/cond_eval.sv
// Purely combinational condition-field evaluator: does a 4-bit condition
// pass under the given {N,Z,C,V} flags.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = nzcv[N_BIT];
    assign w_z = nzcv[Z_BIT];
    assign w_c = nzcv[C_BIT];
    assign w_v = nzcv[V_BIT];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = w_z;
            COND_NE: pass = ~w_z;
            COND_CS: pass = w_c;
            COND_CC: pass = ~w_c;
            COND_MI: pass = w_n;
            COND_PL: pass = ~w_n;
            COND_VS: pass = w_v;
            COND_VC: pass = ~w_v;
            COND_HI: pass = w_c & ~w_z;
            COND_LS: pass = ~w_c | w_z;
            COND_GE: pass = (w_n == w_v);
            COND_LT: pass = (w_n != w_v);
            COND_GT: pass = ~w_z & (w_n == w_v);
            COND_LE: pass = w_z | (w_n != w_v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_issue_queue.sv
// Fetch-to-decode instruction FIFO that issues its head with an execute flag
// derived from the instruction condition field and the live CPSR flags.
module cond_issue_queue
    import cond_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int COND_LSB = 28,
    parameter int SKIP_W   = 16
) (
    input  logic                       clk,
    input  logic                       Rst_n,
    input  logic                       flush,
    input  logic [3:0]                 nzcv,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_inst,
    output logic                       out_exec,
    output logic [$clog2(DEPTH):0]     count,
    output logic [SKIP_W-1:0]          skip_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [SKIP_W-1:0] r_skip;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_pass;
    logic [DATA_W-1:0] w_head;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];

    // No push-through at full: in_ready ignores a same-cycle pop.
    assign in_ready  = ~w_full & ~flush;
    assign out_valid = ~w_empty;
    assign out_inst  = w_empty ? '0 : w_head;
    assign out_exec  = ~w_empty & w_pass;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready & ~flush;

    cond_eval u_cond_eval (
        .cond (w_head[COND_LSB+3:COND_LSB]),
        .nzcv (nzcv),
        .pass (w_pass)
    );

    // Storage is deliberately left out of reset; occupancy gates its visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_inst;
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Skipped-instruction counter survives flush and saturates at all-ones.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_skip <= '0;
        end else if (w_pop && !out_exec && (r_skip != '1)) begin
            r_skip <= r_skip + SKIP_W'(1);
        end
    end

    assign count    = r_count;
    assign skip_cnt = r_skip;

endmodule

// File: doc/cond_issue_queue.md
Name: cond_issue_queue

Overview:
- Parametrised instruction buffer between instruction ROM fetch and decode.
- Accepts fetched instructions over a valid/ready handshake and holds them in a FIFO of configurable depth.
- Issues the head entry with a per-instruction execute flag, computed from its condition field against the current CPSR NZCV.
- Supports a pipeline flush for branches, and counts instructions that were condition-skipped.

Parameters:
- DATA_W, 32: instruction width in bits.
- DEPTH, 4: FIFO entries. Must be a power of two, at least 2.
- COND_LSB, 28: bit position of the 4-bit condition field within the instruction.
- SKIP_W, 16: width of the skipped-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous queue clear (branch taken).
- nzcv  in  4  CPSR flags as {N,Z,C,V}, i.e. bit3=N, bit0=V.
- in_valid  in  1  fetch side has an instruction.
- in_ready  out  1  queue can accept.
- in_inst  in  DATA_W  fetched instruction.
- out_valid  out  1  head entry available.
- out_ready  in  1  decode consumes the head.
- out_inst  out  DATA_W  head instruction.
- out_exec  out  1  head condition passes under the current nzcv.
- count  out  $clog2(DEPTH)+1  current occupancy.
- skip_cnt  out  SKIP_W  number of issued instructions with out_exec=0.

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - read pointer, write pointer, count and skip_cnt go to 0.
  - out_valid=0, out_inst=0, out_exec=0, in_ready=1 once Rst_n deasserts.
  - Storage array is not reset.
- push = in_valid & in_ready. Writes in_inst at the write pointer; the pointer increments modulo DEPTH.
- pop = out_valid & out_ready. The read pointer increments modulo DEPTH.
- in_ready = (count < DEPTH) & ~flush. There is no push-through when full: a simultaneous pop at full still leaves in_ready=0 that cycle.
- out_valid = (count != 0). When empty, out_inst=0 and out_exec=0.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - Count never exceeds DEPTH and never underflows.
- Latency: an instruction pushed at edge k is visible at out_inst after edge k; minimum one cycle fetch-to-issue. Full throughput is 1/cycle when neither full nor empty.
- out_exec is combinational from the head condition field cond = out_inst[COND_LSB+3:COND_LSB] and nzcv:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z.
  - GE N==V; LT N!=V.
  - GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 4'b1111 (NV) 0.
- A head entry whose condition fails is still issued (out_valid=1, out_exec=0); decode treats it as a NOP. The queue never silently drops entries.
- skip_cnt increments by 1 on each pop with out_exec=0. It saturates at all-ones and never wraps. It is cleared only by reset, not by flush.
- flush=1 at an edge:
  - pointers and count go to 0.
  - Any push or pop in the same cycle is discarded; a pop in the flush cycle does not update skip_cnt.
  - Queue is empty the following cycle.
- Changes on nzcv mid-stall are reflected in out_exec immediately. Decode samples out_exec together with pop.
- Rst_n asserted mid-operation: all state is lost; behaves as reset above regardless of flush or handshakes.

Decomposition:
- Shared package cond_pkg:
  - 4-bit condition-code localparams COND_EQ..COND_NV.
  - NZCV bit index constants N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
- Sub-module cond_eval: purely combinational (cond[3:0], nzcv[3:0]) -> pass. Reused later by the branch unit.
- Top cond_issue_queue holds the FIFO storage, pointers, count, skip counter and handshake logic.

Test Plan:
- Reset then push 0xE3A01005, 0x03A02001, 0x13A03002 with nzcv=4'b0100, out_ready=0 -> count=3.
  - Then pop all three -> out_exec sequence 1,1,0; skip_cnt=1; count=0, out_valid=0.
- DEPTH=4: push 5 back-to-back with out_ready=0 -> in_ready drops after the 4th; count=4; 5th held off.
  - Then push+pop in the same cycle at full -> no write; count=3.
- Wrap-around: 12 continuous push/pop cycles with values 0xE0000000+i -> out_inst order equals in_inst order; count stays 1.
- Condition sweep: head held with cond=0..15 across all 16 nzcv values -> out_exec matches the table in Behaviour, including LS with C=1,Z=1 -> 1 and NV -> 0.
- Flush with count=3 plus simultaneous push and pop -> next cycle count=0, out_valid=0, skip_cnt unchanged.
- SKIP_W=2: pop 5 failing-condition entries -> skip_cnt saturates at 3. Assert Rst_n=0 asynchronously mid-cycle -> all outputs reset immediately.
